eth_preamble_ifg_tx: RTL and testbench

Parametrised Ethernet transmit framer. It accepts a payload byte stream over a valid/ready handshake and emits a GMII-style byte stream: a configurable preamble, then the SFD, then the payload, then optional zero padding, with a guaranteed minimum inter-packet gap. It sits between the TX frame/CRC datapath and the PHY-side output registers. It adds underrun detection and abort signalling, padding and IFG enforcement that the fixed 7+1 preamble generator lacks.

---
 rtl/eth_preamble_ifg_tx.sv | 150 +++++++++++++++
 tb/tb_eth_preamble_ifg_tx.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_preamble_ifg_tx.sv
// Ethernet transmit framer: wraps a payload byte stream with preamble and SFD,
// zero-pads short frames, flags underruns with tx_er and enforces a minimum
// inter-packet gap before the next frame may start.
module eth_preamble_ifg_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MIN_PAYLOAD  = 60
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;
    localparam logic [2:0] S_IFG      = 3'd6;

    localparam logic [3:0]  PRE_LAST  = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_LEN - 1);
    localparam logic [10:0] MIN_BYTES = 11'(MIN_PAYLOAD);

    logic [2:0]  state;
    logic [3:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [10:0] byte_next;
    logic [7:0]  ifg_cnt;
    logic        aborted;
    logic        accept;

    // Payload is only taken while streaming or while flushing an aborted frame
    assign s_axis_tready = (state == S_PAYLOAD) || (state == S_DRAIN);
    assign busy          = (state != S_IDLE);
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Payload/pad byte count including the current byte, saturating at 2047
    always_comb begin
        byte_next = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    end

    // Framing state machine; every output byte is registered, idle bytes are zero
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            pre_cnt    <= 4'd0;
            byte_cnt   <= 11'd0;
            ifg_cnt    <= 8'd0;
            aborted    <= 1'b0;
            txd        <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            txd        <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s_axis_tvalid) begin
                        state   <= S_PREAMBLE;
                        pre_cnt <= 4'd0;
                        aborted <= 1'b0;
                    end
                end
                S_PREAMBLE: begin
                    txd   <= 8'h55;
                    tx_en <= 1'b1;
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt <= 4'd0;
                        state   <= S_SFD;
                    end else begin
                        pre_cnt <= pre_cnt + 4'd1;
                    end
                end
                S_SFD: begin
                    txd      <= 8'hD5;
                    tx_en    <= 1'b1;
                    byte_cnt <= 11'd0;
                    state    <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    tx_en <= 1'b1;
                    if (s_axis_tvalid) begin
                        txd      <= s_axis_tdata;
                        byte_cnt <= byte_next;
                        if (s_axis_tlast) begin
                            ifg_cnt <= 8'd0;
                            state   <= (byte_next >= MIN_BYTES) ? S_IFG : S_PAD;
                        end
                    end else begin
                        tx_er    <= 1'b1;
                        underrun <= 1'b1;
                        aborted  <= 1'b1;
                        state    <= S_DRAIN;
                    end
                end
                S_PAD: begin
                    tx_en    <= 1'b1;
                    byte_cnt <= byte_next;
                    if (byte_next >= MIN_BYTES) begin
                        ifg_cnt <= 8'd0;
                        state   <= S_IFG;
                    end
                end
                S_DRAIN: begin
                    if (accept && s_axis_tlast) begin
                        ifg_cnt <= 8'd0;
                        state   <= S_IFG;
                    end
                end
                S_IFG: begin
                    if ((ifg_cnt == 8'd0) && !aborted) begin
                        frame_done <= 1'b1;
                    end
                    if (ifg_cnt == IFG_LAST) begin
                        ifg_cnt <= 8'd0;
                        if (s_axis_tvalid) begin
                            state   <= S_PREAMBLE;
                            pre_cnt <= 4'd0;
                            aborted <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        ifg_cnt <= ifg_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_preamble_ifg_tx.sv
// Self-checking bench for eth_preamble_ifg_tx: expected output bytes are queued
// as each frame is set up and popped as the DUT drives tx_en, plus timing checks.
module tb_eth_preamble_ifg_tx;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    logic [7:0] tdata2;
    logic       tvalid2;
    logic       tlast2;
    logic       tready2;
    logic [7:0] txd2;
    logic       tx_en2;
    logic       tx_er2;
    logic       busy2;
    logic       frame_done2;
    logic       underrun2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cap_txd[$];
    logic       cap_en[$];
    logic       cap_er[$];
    logic       cap_done[$];
    logic       cap_urun[$];
    logic       cap_rdy[$];
    logic       cap_busy[$];

    // Free-running clock
    always #5 aclk = ~aclk;

    eth_preamble_ifg_tx #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_PAYLOAD(60)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .tx_en         (tx_en),
        .tx_er         (tx_er),
        .busy          (busy),
        .frame_done    (frame_done),
        .underrun      (underrun)
    );

    eth_preamble_ifg_tx #(.PREAMBLE_LEN(3), .IFG_LEN(12), .MIN_PAYLOAD(0)) dut_short (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (tdata2),
        .s_axis_tvalid (tvalid2),
        .s_axis_tlast  (tlast2),
        .s_axis_tready (tready2),
        .txd           (txd2),
        .tx_en         (tx_en2),
        .tx_er         (tx_er2),
        .busy          (busy2),
        .frame_done    (frame_done2),
        .underrun      (underrun2)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic capture_clear();
        cap_txd.delete();
        cap_en.delete();
        cap_er.delete();
        cap_done.delete();
        cap_urun.delete();
        cap_rdy.delete();
        cap_busy.delete();
    endtask

    task automatic capture_sample();
        cap_txd.push_back(txd);
        cap_en.push_back(tx_en);
        cap_er.push_back(tx_er);
        cap_done.push_back(frame_done);
        cap_urun.push_back(underrun);
        cap_rdy.push_back(s_axis_tready);
        cap_busy.push_back(busy);
    endtask

    task automatic push_preamble(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{d: 8'h55, er: 1'b0});
        exp_q.push_back('{d: 8'hD5, er: 1'b0});
    endtask

    // Streams nframes frames of nbytes (data = byte index) with a one-cycle
    // tvalid gap before byte drop_at (-1 for none), recording every cycle.
    task automatic run_frames(input int nframes, input int nbytes, input int drop_at, input int cycles);
        int k;
        int f;
        bit dropped;
        bit acc;
        bit lst;
        k = 0;
        f = 0;
        dropped = 1'b0;
        capture_clear();
        for (int c = 0; c < cycles; c++) begin
            if (f < nframes) begin
                if (!dropped && (k == drop_at) && s_axis_tready) begin
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                    dropped       = 1'b1;
                end else begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = 8'(k);
                    s_axis_tlast  = (k == nbytes - 1);
                end
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_axis_tdata  = 8'h00;
            end
            acc = s_axis_tvalid && s_axis_tready;
            lst = s_axis_tlast;
            tick();
            if (acc) begin
                if (lst) begin
                    k = 0;
                    f++;
                end else begin
                    k++;
                end
            end
            capture_sample();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        tvalid2       = 1'b0;
        tlast2        = 1'b0;
        tdata2        = 8'h00;
        tick();
        tick();
        checks++; if (txd !== 8'h00) begin errors++; $display("[TB] FAIL reset_txd got %h want 00", txd); end
        checks++; if (tx_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_en got %b want 0", tx_en); end
        checks++; if (tx_er !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_er got %b want 0", tx_er); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got %b want 0", underrun); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready got %b want 0", s_axis_tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if ({tx_en2, txd2, busy2} !== 10'h000) begin errors++; $display("[TB] FAIL reset_short got %h want 000", {tx_en2, txd2, busy2}); end
        aresetn = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        int en_cnt;
        int first;
        int done_cnt;
        int done_at;
        int er_cnt;
        int idle_bad;
        exp_t e;
        en_cnt = 0; first = -1; done_cnt = 0; done_at = -1; er_cnt = 0; idle_bad = 0;
        exp_q.delete();
        push_preamble(7);
        for (int i = 0; i < 64; i++) exp_q.push_back('{d: 8'(i), er: 1'b0});
        run_frames(1, 64, -1, 100);
        foreach (cap_en[i]) begin
            if (cap_en[i] === 1'b1) begin
                en_cnt++;
                if (first < 0) first = i;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL full_extra_byte cycle %0d got %h want none", i, cap_txd[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (cap_txd[i] !== e.d || cap_er[i] !== e.er) begin
                        errors++; $display("[TB] FAIL full_byte cycle %0d got %h/%b want %h/%b", i, cap_txd[i], cap_er[i], e.d, e.er);
                    end
                end
            end else if (cap_txd[i] !== 8'h00) begin
                idle_bad++;
            end
            if (cap_done[i] === 1'b1) begin done_cnt++; done_at = i; end
            if (cap_er[i] !== 1'b0 || cap_urun[i] !== 1'b0) er_cnt++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL full_missing got %0d left want 0", exp_q.size()); end
        checks++; if (en_cnt != 72) begin errors++; $display("[TB] FAIL full_en_cycles got %0d want 72", en_cnt); end
        checks++; if (first != 1) begin errors++; $display("[TB] FAIL full_start_latency got %0d want 1", first); end
        checks++; if (done_cnt != 1 || done_at != 73) begin errors++; $display("[TB] FAIL full_frame_done got %0d@%0d want 1@73", done_cnt, done_at); end
        checks++; if (er_cnt != 0) begin errors++; $display("[TB] FAIL full_tx_er got %0d want 0", er_cnt); end
        checks++; if (idle_bad != 0) begin errors++; $display("[TB] FAIL full_idle_txd got %0d nonzero want 0", idle_bad); end
    endtask

    task automatic test_padding();
        int en_cnt;
        int done_cnt;
        int done_at;
        int rdy_cnt;
        exp_t e;
        en_cnt = 0; done_cnt = 0; done_at = -1; rdy_cnt = 0;
        exp_q.delete();
        push_preamble(7);
        for (int i = 0; i < 10; i++) exp_q.push_back('{d: 8'(i), er: 1'b0});
        for (int i = 0; i < 50; i++) exp_q.push_back('{d: 8'h00, er: 1'b0});
        run_frames(1, 10, -1, 100);
        foreach (cap_en[i]) begin
            if (cap_en[i] === 1'b1) begin
                en_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL pad_extra_byte cycle %0d got %h want none", i, cap_txd[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (cap_txd[i] !== e.d || cap_er[i] !== e.er) begin
                        errors++; $display("[TB] FAIL pad_byte cycle %0d got %h/%b want %h/%b", i, cap_txd[i], cap_er[i], e.d, e.er);
                    end
                end
            end
            if (cap_done[i] === 1'b1) begin done_cnt++; done_at = i; end
            if (cap_rdy[i] === 1'b1) rdy_cnt++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL pad_missing got %0d left want 0", exp_q.size()); end
        checks++; if (en_cnt != 68) begin errors++; $display("[TB] FAIL pad_en_cycles got %0d want 68", en_cnt); end
        checks++; if (done_cnt != 1 || done_at != 69) begin errors++; $display("[TB] FAIL pad_frame_done got %0d@%0d want 1@69", done_cnt, done_at); end
        checks++; if (rdy_cnt != 10) begin errors++; $display("[TB] FAIL pad_tready_cycles got %0d want 10", rdy_cnt); end
    endtask

    task automatic test_back_to_back();
        int en_cnt;
        int done_cnt;
        int last1;
        int first2;
        exp_t e;
        en_cnt = 0; done_cnt = 0; last1 = -1; first2 = -1;
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            push_preamble(7);
            for (int i = 0; i < 64; i++) exp_q.push_back('{d: 8'(i), er: 1'b0});
        end
        run_frames(2, 64, -1, 200);
        foreach (cap_en[i]) begin
            if (cap_en[i] === 1'b1) begin
                en_cnt++;
                if (en_cnt == 72) last1 = i;
                if (en_cnt == 73) first2 = i;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_extra_byte cycle %0d got %h want none", i, cap_txd[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (cap_txd[i] !== e.d || cap_er[i] !== e.er) begin
                        errors++; $display("[TB] FAIL b2b_byte cycle %0d got %h/%b want %h/%b", i, cap_txd[i], cap_er[i], e.d, e.er);
                    end
                end
            end
            if (cap_done[i] === 1'b1) done_cnt++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_missing got %0d left want 0", exp_q.size()); end
        checks++; if (en_cnt != 144) begin errors++; $display("[TB] FAIL b2b_en_cycles got %0d want 144", en_cnt); end
        checks++; if (first2 - last1 - 1 != 12) begin errors++; $display("[TB] FAIL b2b_gap got %0d want 12", first2 - last1 - 1); end
        checks++; if (done_cnt != 2) begin errors++; $display("[TB] FAIL b2b_frame_done got %0d want 2", done_cnt); end
    endtask

    task automatic test_underrun();
        int en_cnt;
        int done_cnt;
        int er_cnt;
        int urun_at;
        int rdy_cnt;
        exp_t e;
        en_cnt = 0; done_cnt = 0; er_cnt = 0; urun_at = -1; rdy_cnt = 0;
        exp_q.delete();
        push_preamble(7);
        for (int i = 0; i < 20; i++) exp_q.push_back('{d: 8'(i), er: 1'b0});
        exp_q.push_back('{d: 8'h00, er: 1'b1});
        run_frames(1, 64, 20, 100);
        foreach (cap_en[i]) begin
            if (cap_en[i] === 1'b1) begin
                en_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL urun_extra_byte cycle %0d got %h want none", i, cap_txd[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (cap_txd[i] !== e.d || cap_er[i] !== e.er) begin
                        errors++; $display("[TB] FAIL urun_byte cycle %0d got %h/%b want %h/%b", i, cap_txd[i], cap_er[i], e.d, e.er);
                    end
                end
            end
            if (cap_done[i] === 1'b1) done_cnt++;
            if (cap_er[i] === 1'b1) er_cnt++;
            if (cap_urun[i] === 1'b1) urun_at = (urun_at < 0) ? i : -2;
            if (cap_rdy[i] === 1'b1) rdy_cnt++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL urun_missing got %0d left want 0", exp_q.size()); end
        checks++; if (en_cnt != 29) begin errors++; $display("[TB] FAIL urun_en_cycles got %0d want 29", en_cnt); end
        checks++; if (urun_at != 29) begin errors++; $display("[TB] FAIL urun_pulse got %0d want 29", urun_at); end
        checks++; if (er_cnt != 1) begin errors++; $display("[TB] FAIL urun_tx_er_cycles got %0d want 1", er_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL urun_frame_done got %0d want 0", done_cnt); end
        checks++; if (rdy_cnt != 65) begin errors++; $display("[TB] FAIL urun_tready_cycles got %0d want 65", rdy_cnt); end
        checks++; if (cap_busy[84] !== 1'b1 || cap_busy[85] !== 1'b0) begin
            errors++; $display("[TB] FAIL urun_ifg_end got %b%b want 10", cap_busy[84], cap_busy[85]);
        end
    endtask

    task automatic test_reset_mid_frame();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (tx_en !== 1'b1 || txd !== 8'h55) begin errors++; $display("[TB] FAIL rst_mid_pre4 got %b/%h want 1/55", tx_en, txd); end
        aresetn = 1'b0;
        tick();
        checks++; if (tx_en !== 1'b0 || txd !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_clear got %b/%h/%b want 0/00/0", tx_en, txd, busy);
        end
        aresetn = 1'b1;
        capture_clear();
        for (int c = 0; c < 10; c++) begin
            tick();
            capture_sample();
        end
        checks++; if (cap_en[0] !== 1'b0 || cap_done[0] !== 1'b0 || cap_urun[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_release got %b%b%b want 000", cap_en[0], cap_done[0], cap_urun[0]);
        end
        exp_q.delete();
        push_preamble(7);
        for (int i = 1; i <= 8; i++) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (cap_en[i] !== 1'b1 || cap_txd[i] !== e.d) begin
                errors++; $display("[TB] FAIL rst_mid_restart cycle %0d got %b/%h want 1/%h", i, cap_en[i], cap_txd[i], e.d);
            end
        end
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_cleanup got %b want 0", busy); end
    endtask

    task automatic test_short_preamble_one_byte();
        bit acc;
        bit sent;
        int en_cnt;
        int first;
        int done_at;
        exp_t e;
        logic [7:0] s_txd[$];
        logic       s_en[$];
        logic       s_done[$];
        logic       s_er[$];
        sent = 1'b0; en_cnt = 0; first = -1; done_at = -1;
        exp_q.delete();
        push_preamble(3);
        exp_q.push_back('{d: 8'hA5, er: 1'b0});
        tdata2 = 8'hA5;
        tlast2 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tvalid2 = !sent;
            acc = tvalid2 && tready2;
            tick();
            if (acc) sent = 1'b1;
            s_txd.push_back(txd2);
            s_en.push_back(tx_en2);
            s_done.push_back(frame_done2);
            s_er.push_back(tx_er2);
        end
        tvalid2 = 1'b0;
        tlast2  = 1'b0;
        foreach (s_en[i]) begin
            if (s_en[i] === 1'b1) begin
                en_cnt++;
                if (first < 0) first = i;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL short_extra_byte cycle %0d got %h want none", i, s_txd[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[i] !== e.d || s_er[i] !== e.er) begin
                        errors++; $display("[TB] FAIL short_byte cycle %0d got %h/%b want %h/%b", i, s_txd[i], s_er[i], e.d, e.er);
                    end
                end
            end
            if (s_done[i] === 1'b1) done_at = (done_at < 0) ? i : -2;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL short_missing got %0d left want 0", exp_q.size()); end
        checks++; if (sent !== 1'b1) begin errors++; $display("[TB] FAIL short_accept got %b want 1", sent); end
        checks++; if (en_cnt != 5 || first != 1) begin errors++; $display("[TB] FAIL short_en got %0d@%0d want 5@1", en_cnt, first); end
        checks++; if (done_at != 6) begin errors++; $display("[TB] FAIL short_frame_done got %0d want 6", done_at); end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_full_frame();
        test_padding();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        test_short_preamble_one_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
